// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the register-loaded sequential ALU.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpMul = 3'd5,
    OpShl = 3'd6,
    OpShr = 3'd7
  } op_e;

  typedef enum logic {
    StIdle,
    StMul
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier; one partial product per cycle, M cycles.
module seq_multiplier #(
  parameter int unsigned M = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [2*M-1:0] product,
  output logic           valid
);

  localparam int unsigned CW = $clog2(M);

  logic [M-1:0]   mcand_q;
  logic [2*M-1:0] p_q;
  logic [2*M-1:0] p_step;
  logic [M:0]     sum;
  logic [CW-1:0]  cnt_q;
  logic           running_q;

  // Upper half accumulates, lower half shifts out the multiplier bits.
  always_comb begin
    sum     = {1'b0, p_q[2*M-1:M]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    p_step  = {sum, p_q[M-1:1]};
    // valid marks the final step: product is the value about to be registered.
    valid   = running_q && (cnt_q == CW'(M - 1));
    product = p_step;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (start) begin
      mcand_q   <= a;
      p_q       <= {{M{1'b0}}, b};
      cnt_q     <= '0;
      running_q <= 1'b1;
    end else if (running_q) begin
      p_q   <= p_step;
      cnt_q <= cnt_q + 1'b1;
      if (valid) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_reg_seq.sv
// Register-loaded ALU with multi-cycle multiply, accumulate mode and registered NZCV flags.
module alu_reg_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned M = 16
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic [M-1:0] data_in,
  input  logic         load_A,
  input  logic         load_B,
  input  logic         load_Op,
  input  logic         acc,
  input  logic         updateRes,
  output logic [M-1:0] result,
  output logic [3:0]   flags,
  output logic         busy,
  output logic         done
);

  logic [M-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]     flags_q, flags_d;
  op_e            op_q, op_d;
  state_e         state_q, state_d;
  logic           done_q, done_d, acc_q, acc_d;

  logic [M:0]     ext;
  logic [M-1:0]   alu_res, wr_val;
  logic           alu_c, alu_v, wr_c, wr_v, wr_en, wr_acc;
  logic           start_op, start_mul, mul_valid;
  logic [2*M-1:0] mul_product;

  seq_multiplier #(.M(M)) u_mul (
    .clk     (Clk),
    .reset   (reset),
    .start   (start_mul),
    .a       (a_q),
    .b       (b_q),
    .product (mul_product),
    .valid   (mul_valid)
  );

  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op_q)
      OpAdd: begin
        ext     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = ext[M-1:0];
        alu_c   = ext[M];
        alu_v   = (a_q[M-1] == b_q[M-1]) && (alu_res[M-1] != a_q[M-1]);
      end
      OpSub: begin
        ext     = {1'b0, a_q} - {1'b0, b_q};
        alu_res = ext[M-1:0];
        alu_c   = ~ext[M];
        alu_v   = (a_q[M-1] != b_q[M-1]) && (alu_res[M-1] != a_q[M-1]);
      end
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpXor: alu_res = a_q ^ b_q;
      OpShl: begin
        alu_res = {a_q[M-2:0], 1'b0};
        alu_c   = a_q[M-1];
      end
      OpShr: begin
        alu_res = {1'b0, a_q[M-1:1]};
        alu_c   = a_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    flags_d   = flags_q;
    acc_d     = acc_q;
    start_op  = (state_q == StIdle) && updateRes;
    start_mul = start_op && (op_q == OpMul);
    wr_en     = 1'b0;
    wr_val    = alu_res;
    wr_c      = alu_c;
    wr_v      = alu_v;
    wr_acc    = acc;

    unique case (state_q)
      StIdle: begin
        if (start_mul) begin
          state_d = StMul;
          acc_d   = acc;
        end else if (start_op) begin
          wr_en = 1'b1;
        end
      end
      StMul: begin
        // updateRes is deliberately not looked at here: no queuing while busy.
        if (mul_valid) begin
          state_d = StIdle;
          wr_en   = 1'b1;
          wr_val  = mul_product[M-1:0];
          wr_c    = |mul_product[2*M-1:M];
          wr_v    = 1'b0;
          wr_acc  = acc_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) begin
      result_d        = wr_val;
      flags_d[FLAG_N] = wr_val[M-1];
      flags_d[FLAG_Z] = (wr_val == '0);
      flags_d[FLAG_C] = wr_c;
      flags_d[FLAG_V] = wr_v;
      if (wr_acc) a_d = wr_val;
    end
    done_d = wr_en;

    // Explicit loads override accumulate write-back.
    if (load_A)  a_d  = data_in;
    if (load_B)  b_d  = data_in;
    if (load_Op) op_d = op_e'(data_in[2:0]);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OpAdd;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      acc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign busy   = (state_q == StMul);
  assign done   = done_q;

endmodule

// File: tb/tb_alu_reg_seq.sv
// Directed self-checking bench for alu_reg_seq with hand-computed expected values.
module tb_alu_reg_seq;

  localparam int unsigned M = 16;

  logic         Clk = 1'b0;
  logic         reset;
  logic [M-1:0] data_in;
  logic         load_A, load_B, load_Op, acc, updateRes;
  logic [M-1:0] result;
  logic [3:0]   flags;
  logic         busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_reg_seq #(.M(M)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .data_in   (data_in),
    .load_A    (load_A),
    .load_B    (load_B),
    .load_Op   (load_Op),
    .acc       (acc),
    .updateRes (updateRes),
    .result    (result),
    .flags     (flags),
    .busy      (busy),
    .done      (done)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_reg(input int which, input logic [M-1:0] v);
    data_in = v;
    load_A  = (which == 0);
    load_B  = (which == 1);
    load_Op = (which == 2);
    tick();
    load_A  = 1'b0;
    load_B  = 1'b0;
    load_Op = 1'b0;
  endtask

  task automatic setup(input logic [M-1:0] a, input logic [M-1:0] b, input logic [2:0] op);
    load_reg(0, a);
    load_reg(1, b);
    load_reg(2, {13'd0, op});
  endtask

  task automatic run_op(input logic acc_v);
    updateRes = 1'b1;
    acc       = acc_v;
    tick();
    updateRes = 1'b0;
    acc       = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [M-1:0] r, input logic [3:0] f);
    check_eq({tag, " result"}, result, r);
    check_eq({tag, " flags"}, flags, f);
    check_eq({tag, " done"}, done, 1'b1);
  endtask

  initial begin
    int cycles;
    int early_done;

    reset     = 1'b1;
    data_in   = '0;
    load_A    = 1'b0;
    load_B    = 1'b0;
    load_Op   = 1'b0;
    acc       = 1'b0;
    updateRes = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset result", result, 0);
    check_eq("reset flags", flags, 0);
    check_eq("reset busy", busy, 0);
    check_eq("reset done", done, 0);

    setup(16'd4, 16'd17, 3'd0);
    run_op(1'b0);
    check_out("add 4+17", 16'd21, 4'b0000);
    check_eq("add busy", busy, 0);
    tick();
    check_eq("add done drops", done, 0);
    check_eq("add result holds", result, 16'd21);

    setup(16'd4, 16'd17, 3'd1);
    run_op(1'b0);
    check_out("sub 4-17", 16'hFFF3, 4'b1000);

    setup(16'h7FFF, 16'd1, 3'd0);
    run_op(1'b0);
    check_out("add ovf", 16'h8000, 4'b1001);

    setup(16'hFFFF, 16'd1, 3'd0);
    run_op(1'b0);
    check_out("add carry", 16'h0000, 4'b0110);

    setup(16'hF0F0, 16'hFF00, 3'd2);
    run_op(1'b0);
    check_out("and", 16'hF000, 4'b1000);
    load_reg(2, 16'd4);
    run_op(1'b0);
    check_out("xor", 16'h0FF0, 4'b0000);

    setup(16'h8001, 16'd0, 3'd6);
    run_op(1'b0);
    check_out("shl", 16'h0002, 4'b0010);
    load_reg(2, 16'd7);
    run_op(1'b0);
    check_out("shr", 16'h4000, 4'b0010);

    // Multiply with an ignored updateRes pulse while busy
    setup(16'd300, 16'd300, 3'd5);
    run_op(1'b0);
    check_eq("mul busy start", busy, 1);
    check_eq("mul no early done", done, 0);
    cycles     = 0;
    early_done = 0;
    while (busy === 1'b1 && cycles < 40) begin
      if (cycles == 5) updateRes = 1'b1;
      tick();
      updateRes = 1'b0;
      cycles++;
      if (busy === 1'b1 && done !== 1'b0) early_done++;
    end
    check_eq("mul busy cycles", cycles, M);
    check_eq("mul done during busy", early_done, 0);
    check_out("mul 300*300", 16'h5F90, 4'b0010);
    tick();
    check_eq("mul not restarted", busy, 0);
    check_eq("mul done one cycle", done, 0);
    check_eq("mul result holds", result, 16'h5F90);

    // Accumulate, updateRes held high for back-to-back ops
    setup(16'd5, 16'd3, 3'd0);
    updateRes = 1'b1;
    acc       = 1'b1;
    tick();
    check_out("acc1", 16'd8, 4'b0000);
    tick();
    check_out("acc2", 16'd11, 4'b0000);
    tick();
    check_out("acc3", 16'd14, 4'b0000);
    updateRes = 1'b0;
    acc       = 1'b0;
    load_reg(1, 16'd0);
    load_reg(2, 16'd3);
    run_op(1'b0);
    check_out("acc A readback", 16'd14, 4'b0000);

    // Accumulate with load_A winning on the second pulse
    setup(16'd5, 16'd3, 3'd0);
    run_op(1'b1);
    check_out("accl1", 16'd8, 4'b0000);
    data_in = 16'd1;
    load_A  = 1'b1;
    run_op(1'b1);
    load_A  = 1'b0;
    check_out("accl2", 16'd11, 4'b0000);
    run_op(1'b1);
    check_out("accl3", 16'd4, 4'b0000);

    // Reset mid-multiply
    setup(16'd300, 16'd300, 3'd5);
    run_op(1'b0);
    repeat (4) tick();
    check_eq("mulrst busy before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mulrst result", result, 0);
    check_eq("mulrst flags", flags, 0);
    check_eq("mulrst busy", busy, 0);
    check_eq("mulrst done", done, 0);
    tick();
    check_eq("mulrst no late done", done, 0);
    setup(16'd2, 16'd3, 3'd0);
    run_op(1'b0);
    check_out("post-reset add", 16'd5, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
